// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot scan controller and iteration engine.
// Coordinates are Q4.28 two's-complement.
package mandelbrot_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FRAC_WIDTH_DEF = 28;

  localparam logic [31:0] ONE     = 32'h1000_0000;
  localparam logic [31:0] TWO_NEG = 32'hE000_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_FDONE = 3'd4
  } scan_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mandelbrot_scan_ctrl_if.sv
// Engine job handshake and pixel stream between the scan controller (master)
// and the engine / colour-map writer side (slave).
interface mandelbrot_scan_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int X_W        = 10,
  parameter int Y_W        = 9
);
  logic                  eng_start;
  logic [DATA_WIDTH-1:0] eng_c_real;
  logic [DATA_WIDTH-1:0] eng_c_imag;
  logic [15:0]           eng_max_iter;
  logic [15:0]           eng_iter_count;
  logic                  eng_done;

  logic                  pix_valid;
  logic                  pix_ready;
  logic [X_W-1:0]        pix_x;
  logic [Y_W-1:0]        pix_y;
  logic [15:0]           pix_iter;
  logic                  pix_last;

  modport master (
    output eng_start, eng_c_real, eng_c_imag, eng_max_iter,
    input  eng_iter_count, eng_done,
    output pix_valid, pix_x, pix_y, pix_iter, pix_last,
    input  pix_ready
  );

  modport slave (
    input  eng_start, eng_c_real, eng_c_imag, eng_max_iter,
    output eng_iter_count, eng_done,
    input  pix_valid, pix_x, pix_y, pix_iter, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/mandelbrot_coord_gen.sv
// Raster x/y counters and incremental complex-coordinate accumulators.
// load_i starts a frame at the top-left corner; advance_i steps one pixel in raster order.
module mandelbrot_coord_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int X_W        = $clog2(H_RES),
  parameter int Y_W        = $clog2(V_RES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [DATA_WIDTH-1:0] load_real_i,
  input  logic [DATA_WIDTH-1:0] load_imag_i,
  input  logic [DATA_WIDTH-1:0] row_real_i,
  input  logic [DATA_WIDTH-1:0] step_i,
  output logic [X_W-1:0]        x_o,
  output logic [Y_W-1:0]        y_o,
  output logic [DATA_WIDTH-1:0] c_real_o,
  output logic [DATA_WIDTH-1:0] c_imag_o,
  output logic                  last_o
);
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [DATA_WIDTH-1:0] re_q, re_d;
  logic [DATA_WIDTH-1:0] im_q, im_d;

  // Row wrap reloads the left column and moves one step down (imaginary decreases).
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    re_d = re_q;
    im_d = im_q;
    if (load_i) begin
      x_d  = {X_W{1'b0}};
      y_d  = {Y_W{1'b0}};
      re_d = load_real_i;
      im_d = load_imag_i;
    end else if (advance_i) begin
      if (x_q == X_LAST) begin
        x_d  = {X_W{1'b0}};
        y_d  = y_q + Y_W'(1);
        re_d = row_real_i;
        im_d = im_q - step_i;
      end else begin
        x_d  = x_q + X_W'(1);
        re_d = re_q + step_i;
      end
    end else begin
      x_d  = x_q;
      re_d = re_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= {X_W{1'b0}};
      y_q  <= {Y_W{1'b0}};
      re_q <= {DATA_WIDTH{1'b0}};
      im_q <= {DATA_WIDTH{1'b0}};
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign c_real_o = re_q;
  assign c_imag_o = im_q;
  assign last_o   = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/mandelbrot_scan_ctrl.sv
// Frame-level initiator: walks the raster, runs one engine job per pixel and streams the results.
// Optional cycle counter output perf_frame_cycles is built when MANDEL_SCAN_PERF_EN is defined.
module mandelbrot_scan_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int X_W        = $clog2(H_RES),
  parameter int Y_W        = $clog2(V_RES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] cfg_c_real_min,
  input  logic [DATA_WIDTH-1:0] cfg_c_imag_max,
  input  logic [DATA_WIDTH-1:0] cfg_step,
  input  logic [15:0]           cfg_max_iter,
  mandelbrot_scan_ctrl_if.master bus,
  output logic                  busy,
  output logic                  frame_done
`ifdef MANDEL_SCAN_PERF_EN
  ,
  output logic [31:0]           perf_frame_cycles
`endif
);

  if (FRAC_WIDTH >= DATA_WIDTH) begin : g_frac_bad
    $error("FRAC_WIDTH must be smaller than DATA_WIDTH");
  end

  scan_state_t state_q, state_d;

  logic                  load_s, capture_s, accept_s, advance_s;
  logic [DATA_WIDTH-1:0] real_min_q, step_q;
  logic [15:0]           max_iter_q;
  logic                  eng_start_q, busy_q, frame_done_q;
  logic                  pix_valid_q, pix_last_q;
  logic [X_W-1:0]        pix_x_q;
  logic [Y_W-1:0]        pix_y_q;
  logic [15:0]           pix_iter_q;
  logic [X_W-1:0]        cur_x_s;
  logic [Y_W-1:0]        cur_y_s;
  logic                  cur_last_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = frame_start ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = bus.eng_done ? S_EMIT : S_WAIT;
      S_EMIT: begin
        if (bus.pix_ready) begin
          state_d = pix_last_q ? S_FDONE : S_ISSUE;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    load_s    = 1'b0;
    capture_s = 1'b0;
    accept_s  = 1'b0;
    case (state_q)
      S_IDLE:  load_s    = frame_start;
      S_WAIT:  capture_s = bus.eng_done;
      S_EMIT:  accept_s  = bus.pix_ready;
      default: load_s    = 1'b0;
    endcase
  end

  assign advance_s = accept_s & ~pix_last_q;

  // State-decoded outputs are registered from state_d so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      eng_start_q  <= (state_d == S_ISSUE);
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= (state_d == S_FDONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      real_min_q <= {DATA_WIDTH{1'b0}};
      step_q     <= {DATA_WIDTH{1'b0}};
      max_iter_q <= 16'd0;
    end else if (load_s) begin
      real_min_q <= cfg_c_real_min;
      step_q     <= cfg_step;
      max_iter_q <= cfg_max_iter;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
      pix_x_q     <= {X_W{1'b0}};
      pix_y_q     <= {Y_W{1'b0}};
      pix_iter_q  <= 16'd0;
      pix_last_q  <= 1'b0;
    end else if (capture_s) begin
      pix_valid_q <= 1'b1;
      pix_x_q     <= cur_x_s;
      pix_y_q     <= cur_y_s;
      pix_iter_q  <= bus.eng_iter_count;
      pix_last_q  <= cur_last_s;
    end else if (accept_s) begin
      pix_valid_q <= 1'b0;
    end
  end

  // The first pixel loads straight from cfg_* while the shadows latch the same values.
  mandelbrot_coord_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .H_RES     (H_RES),
    .V_RES     (V_RES),
    .X_W       (X_W),
    .Y_W       (Y_W)
  ) u_coord (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_s),
    .advance_i  (advance_s),
    .load_real_i(cfg_c_real_min),
    .load_imag_i(cfg_c_imag_max),
    .row_real_i (real_min_q),
    .step_i     (step_q),
    .x_o        (cur_x_s),
    .y_o        (cur_y_s),
    .c_real_o   (bus.eng_c_real),
    .c_imag_o   (bus.eng_c_imag),
    .last_o     (cur_last_s)
  );

  assign bus.eng_start    = eng_start_q;
  assign bus.eng_max_iter = max_iter_q;
  assign bus.pix_valid    = pix_valid_q;
  assign bus.pix_x        = pix_x_q;
  assign bus.pix_y        = pix_y_q;
  assign bus.pix_iter     = pix_iter_q;
  assign bus.pix_last     = pix_last_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;

`ifdef MANDEL_SCAN_PERF_EN
  logic [31:0] cyc_q, cyc_d, perf_q, perf_d;

  // The snapshot taken in FDONE includes the FDONE cycle itself.
  always_comb begin
    cyc_d  = cyc_q;
    perf_d = perf_q;
    if (load_s) begin
      cyc_d = 32'd0;
    end else if (state_q != S_IDLE) begin
      cyc_d = sat_inc32(cyc_q);
    end else begin
      cyc_d = cyc_q;
    end
    if (state_q == S_FDONE) begin
      perf_d = sat_inc32(cyc_q);
    end else begin
      perf_d = perf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= 32'd0;
      perf_q <= 32'd0;
    end else begin
      cyc_q  <= cyc_d;
      perf_q <= perf_d;
    end
  end

  assign perf_frame_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mandelbrot_scan_ctrl.sv
// Directed bench for mandelbrot_scan_ctrl on a 4x3 raster with a behavioural engine and sink.
module tb_mandelbrot_scan_ctrl;
  localparam int DW = 32;
  localparam int HR = 4;
  localparam int VR = 3;
  localparam int XW = 2;
  localparam int YW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [31:0]   cfg_c_real_min, cfg_c_imag_max, cfg_step;
  logic [15:0]   cfg_max_iter;
  logic          busy, frame_done;
`ifdef MANDEL_SCAN_PERF_EN
  logic [31:0]   perf_frame_cycles;
`endif

  int total = 0;
  int bad   = 0;

  mandelbrot_scan_ctrl_if #(.DATA_WIDTH(DW), .X_W(XW), .Y_W(YW)) bus();

  mandelbrot_scan_ctrl #(
    .DATA_WIDTH(DW), .FRAC_WIDTH(28), .H_RES(HR), .V_RES(VR), .X_W(XW), .Y_W(YW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .cfg_c_real_min (cfg_c_real_min),
    .cfg_c_imag_max (cfg_c_imag_max),
    .cfg_step       (cfg_step),
    .cfg_max_iter   (cfg_max_iter),
    .bus            (bus),
    .busy           (busy),
    .frame_done     (frame_done)
`ifdef MANDEL_SCAN_PERF_EN
    ,
    .perf_frame_cycles(perf_frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Per-frame observations
  logic [31:0] c_re [16];
  logic [31:0] c_im [16];
  logic [1:0]  bx [16];
  logic [1:0]  by [16];
  logic [15:0] bi [16];
  logic        bl [16];
  int beats, starts, start_wide, c_unstable, pix_unstable, start_in_stall, stall_seen;
  int fd_count, fd_delay, busy_cycles;
  bit timed_out, end_busy;

  // Drives one frame: engine answers lat cycles after entering WAIT with count = job index,
  // the sink optionally stalls one beat, and the frame may be aborted in WAIT of a given job.
  task automatic run_frame(input int lat, input int stall_idx, input int stall_len,
                           input bit poke, input int abort_job);
    int cd, last_acc, tail;
    bit pend, held, prev_start, stop;
    logic [31:0] cr, ci;
    logic [1:0]  hx, hy;
    logic [15:0] hi;
    logic        hl;
    beats = 0; starts = 0; start_wide = 0; c_unstable = 0; pix_unstable = 0;
    start_in_stall = 0; stall_seen = 0; fd_count = 0; fd_delay = -1; busy_cycles = 0;
    timed_out = 1'b0; end_busy = 1'b0;
    cd = 0; last_acc = 0; tail = -1; pend = 1'b0; held = 1'b0; prev_start = 1'b0; stop = 1'b0;
    cr = 32'd0; ci = 32'd0; hx = 2'd0; hy = 2'd0; hi = 16'd0; hl = 1'b0;
    bus.eng_done = 1'b0;
    bus.pix_ready = 1'b0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !stop; cyc++) begin
      if (busy) busy_cycles++;
      bus.eng_done = 1'b0;
      if (bus.eng_start) begin
        if (prev_start) start_wide++;
        if (bus.pix_valid) start_in_stall++;
        if (starts < 16) begin
          c_re[starts] = bus.eng_c_real;
          c_im[starts] = bus.eng_c_imag;
        end
        cr = bus.eng_c_real;
        ci = bus.eng_c_imag;
        starts++;
        pend = 1'b1;
        cd = lat + 1;
      end else if (pend) begin
        if (abort_job >= 0 && starts == abort_job + 1) begin
          rst = 1'b1;
          stop = 1'b1;
          pend = 1'b0;
        end else begin
          if (bus.eng_c_real !== cr || bus.eng_c_imag !== ci) c_unstable++;
          cd--;
          if (cd == 0) begin
            bus.eng_done = 1'b1;
            bus.eng_iter_count = 16'(starts - 1);
            pend = 1'b0;
          end
        end
      end
      prev_start = bus.eng_start;
      if (bus.pix_valid) begin
        if (!held) begin
          hx = bus.pix_x; hy = bus.pix_y; hi = bus.pix_iter; hl = bus.pix_last; held = 1'b1;
        end else if ({bus.pix_x, bus.pix_y, bus.pix_iter, bus.pix_last} !== {hx, hy, hi, hl}) begin
          pix_unstable++;
        end
        if (beats == stall_idx && stall_seen < stall_len) begin
          bus.pix_ready = 1'b0;
          stall_seen++;
        end else begin
          bus.pix_ready = 1'b1;
          if (beats < 16) begin
            bx[beats] = bus.pix_x; by[beats] = bus.pix_y;
            bi[beats] = bus.pix_iter; bl[beats] = bus.pix_last;
          end
          beats++;
          held = 1'b0;
          last_acc = cyc;
        end
      end else begin
        bus.pix_ready = 1'b0;
      end
      if (frame_done) begin
        fd_count++;
        fd_delay = cyc - last_acc;
        if (tail < 0) tail = 3;
      end
      if (tail == 0) stop = 1'b1;
      else if (tail > 0) tail--;
      if (poke) begin
        frame_start = (cyc == 30);
        if (cyc == 30) cfg_step = 32'h0100_0000;
      end
      if (!stop) begin
        @(posedge clk); #1;
      end
    end
    if (!stop) timed_out = 1'b1;
    end_busy = busy;
    frame_start = 1'b0;
    bus.pix_ready = 1'b0;
    bus.eng_done = 1'b0;
  endtask

  task automatic set_cfg();
    cfg_c_real_min = 32'hE000_0000;
    cfg_c_imag_max = 32'h1000_0000;
    cfg_step       = 32'h0800_0000;
    cfg_max_iter   = 16'd100;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.eng_start, bus.eng_c_real, bus.eng_c_imag, bus.eng_max_iter} !== 81'd0) begin
      bad++; $display("FAIL reset_eng: got %0h expected 0", {bus.eng_start, bus.eng_c_real, bus.eng_c_imag, bus.eng_max_iter});
    end
    total++;
    if ({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_iter, bus.pix_last} !== 22'd0) begin
      bad++; $display("FAIL reset_pix: got %0h expected 0", {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_iter, bus.pix_last});
    end
    total++;
    if ({busy, frame_done} !== 2'b00) begin
      bad++; $display("FAIL reset_status: got %b expected 00", {busy, frame_done});
    end
`ifdef MANDEL_SCAN_PERF_EN
    total++;
    if (perf_frame_cycles !== 32'd0) begin
      bad++; $display("FAIL reset_perf: got %0h expected 0", perf_frame_cycles);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_scan_coords();
    int errs;
    logic [31:0] er, ei;
    set_cfg();
    run_frame(2, -1, 0, 1'b0, -1);
    total++;
    if (timed_out || beats !== 12) begin
      bad++; $display("FAIL s1_beats: got %0d (timeout %0d) expected 12", beats, timed_out);
    end
    total++;
    if (c_re[0] !== 32'hE000_0000 || c_im[0] !== 32'h1000_0000) begin
      bad++; $display("FAIL s1_c00: got %h,%h expected e0000000,10000000", c_re[0], c_im[0]);
    end
    total++;
    if (c_re[3] !== 32'hF800_0000) begin
      bad++; $display("FAIL s1_c30: got %h expected f8000000", c_re[3]);
    end
    total++;
    if (c_re[8] !== 32'hE000_0000 || c_im[8] !== 32'h0000_0000) begin
      bad++; $display("FAIL s1_c02: got %h,%h expected e0000000,00000000", c_re[8], c_im[8]);
    end
    errs = 0;
    for (int j = 0; j < 12; j++) begin
      er = 32'hE000_0000 + 32'(j % 4) * 32'h0800_0000;
      ei = 32'h1000_0000 - 32'(j / 4) * 32'h0800_0000;
      if (c_re[j] !== er || c_im[j] !== ei) errs++;
      if (bl[j] !== (j == 11)) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL s1_coords_last: got %0d bad entries expected 0", errs);
    end
    total++;
    if (bus.eng_max_iter !== 16'd100) begin
      bad++; $display("FAIL s1_max_iter: got %0d expected 100", bus.eng_max_iter);
    end
  endtask

  task automatic test_iter_handshake();
    int errs;
    set_cfg();
    run_frame(3, -1, 0, 1'b0, -1);
    errs = 0;
    for (int j = 0; j < 12; j++) begin
      if (bx[j] !== 2'(j % 4) || by[j] !== 2'(j / 4)) errs++;
      if (bi[j] !== 16'((j % 4) + 4 * (j / 4))) errs++;
    end
    total++;
    if (timed_out || errs !== 0) begin
      bad++; $display("FAIL s2_pix_iter: got %0d bad entries (timeout %0d) expected 0", errs, timed_out);
    end
    total++;
    if (starts !== 12 || start_wide !== 0) begin
      bad++; $display("FAIL s2_starts: got %0d starts %0d wide expected 12 starts 0 wide", starts, start_wide);
    end
    total++;
    if (c_unstable !== 0) begin
      bad++; $display("FAIL s2_c_stable: got %0d changes expected 0", c_unstable);
    end
  endtask

  task automatic test_backpressure();
    set_cfg();
    run_frame(1, 5, 5, 1'b0, -1);
    total++;
    if (stall_seen !== 5 || bx[5] !== 2'd1 || by[5] !== 2'd1 || bi[5] !== 16'd5) begin
      bad++; $display("FAIL s3_stall_beat: got stall %0d at (%0d,%0d) iter %0d expected 5 at (1,1) iter 5",
                      stall_seen, bx[5], by[5], bi[5]);
    end
    total++;
    if (pix_unstable !== 0 || start_in_stall !== 0) begin
      bad++; $display("FAIL s3_hold: got %0d pix changes %0d early starts expected 0 0", pix_unstable, start_in_stall);
    end
    total++;
    if (timed_out || beats !== 12) begin
      bad++; $display("FAIL s3_beats: got %0d expected 12", beats);
    end
  endtask

  task automatic test_midframe_ignore();
    int errs;
    set_cfg();
    run_frame(2, -1, 0, 1'b1, -1);
    errs = 0;
    for (int j = 0; j < 12; j++) begin
      if (c_re[j] !== 32'hE000_0000 + 32'(j % 4) * 32'h0800_0000) errs++;
      if (c_im[j] !== 32'h1000_0000 - 32'(j / 4) * 32'h0800_0000) errs++;
    end
    total++;
    if (timed_out || errs !== 0 || starts !== 12) begin
      bad++; $display("FAIL s4_latched_step: got %0d bad coords %0d starts expected 0 12", errs, starts);
    end
    total++;
    if (fd_count !== 1 || fd_delay !== 1) begin
      bad++; $display("FAIL s4_frame_done: got count %0d delay %0d expected 1 1", fd_count, fd_delay);
    end
    total++;
    if (end_busy !== 1'b0) begin
      bad++; $display("FAIL s4_idle_after: got busy %b expected 0", end_busy);
    end
    set_cfg();
  endtask

  task automatic test_reset_abort();
    set_cfg();
    run_frame(2, -1, 0, 1'b0, 6);
    total++;
    if (starts !== 7 || beats !== 6 || fd_count !== 0) begin
      bad++; $display("FAIL s5_abort_point: got starts %0d beats %0d fd %0d expected 7 6 0", starts, beats, fd_count);
    end
    @(posedge clk); #1;
    total++;
    if ({bus.eng_start, bus.eng_c_real, bus.eng_c_imag, bus.eng_max_iter,
         bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_iter, bus.pix_last, busy, frame_done} !== 105'd0) begin
      bad++; $display("FAIL s5_reset_outputs: got c=%h,%h valid %b busy %b expected all 0",
                      bus.eng_c_real, bus.eng_c_imag, bus.pix_valid, busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(2, -1, 0, 1'b0, -1);
    total++;
    if (timed_out || beats !== 12 || bx[0] !== 2'd0 || by[0] !== 2'd0 ||
        c_re[0] !== 32'hE000_0000 || c_im[0] !== 32'h1000_0000 || fd_count !== 1) begin
      bad++; $display("FAIL s5_restart: got beats %0d first (%0d,%0d) c=%h,%h fd %0d expected 12 (0,0) e0000000,10000000 1",
                      beats, bx[0], by[0], c_re[0], c_im[0], fd_count);
    end
  endtask

`ifdef MANDEL_SCAN_PERF_EN
  task automatic test_perf();
    set_cfg();
    run_frame(10, -1, 0, 1'b0, -1);
    total++;
    if (busy_cycles !== 157) begin
      bad++; $display("FAIL s6_busy_cycles: got %0d expected 157", busy_cycles);
    end
    total++;
    if (perf_frame_cycles !== 32'd157) begin
      bad++; $display("FAIL s6_perf: got %0d expected 157", perf_frame_cycles);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    bus.eng_done = 1'b0;
    bus.eng_iter_count = 16'd0;
    bus.pix_ready = 1'b0;
    set_cfg();
    test_reset();
    test_scan_coords();
    test_iter_handshake();
    test_backpressure();
    test_midframe_ignore();
    test_reset_abort();
`ifdef MANDEL_SCAN_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mandelbrot_scan_ctrl.md
Name: mandelbrot_scan_ctrl

Overview:
- Frame-level initiator for the Mandelbrot iteration engine.
- Walks a raster of H_RES x V_RES pixels and derives each pixel's complex coordinate c incrementally.
- For each pixel it issues start to the engine, waits for done, captures the iteration count, and emits one pixel beat on a valid/ready stream to the colour-map/framebuffer writer.
- Sits between the host config registers and the engine.

Parameters:
- DATA_WIDTH, 32, fixed-point width of coordinates (Q4.28).
- FRAC_WIDTH, 28, fractional bits; documents the format only, no arithmetic depends on it.
- H_RES, 640, pixels per row.
- V_RES, 480, rows per frame.
- X_W, $clog2(H_RES), pixel x width.
- Y_W, $clog2(V_RES), pixel y width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  pulse; begins a frame when idle.
- cfg_c_real_min  in  DATA_WIDTH  signed real part of the left column.
- cfg_c_imag_max  in  DATA_WIDTH  signed imaginary part of the top row.
- cfg_step  in  DATA_WIDTH  signed per-pixel coordinate step.
- cfg_max_iter  in  16  iteration limit.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_c_real  out  DATA_WIDTH  c real to the engine.
- eng_c_imag  out  DATA_WIDTH  c imag to the engine.
- eng_max_iter  out  16  latched iteration limit.
- eng_iter_count  in  16  engine result.
- eng_done  in  1  engine done pulse.
- pix_valid  out  1  pixel beat valid.
- pix_ready  in  1  downstream accept.
- pix_x  out  X_W  pixel column.
- pix_y  out  Y_W  pixel row.
- pix_iter  out  16  iteration count.
- pix_last  out  1  high on the final pixel of the frame.
- busy  out  1  high when the controller is not in IDLE.
- frame_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: state IDLE; every output 0, including eng_c_*, eng_max_iter, pix_*, busy and frame_done; x/y counters and coordinate accumulators 0.
- States: IDLE, ISSUE, WAIT, EMIT, FDONE.
- IDLE:
  - On frame_start, latch cfg_* into shadow registers.
  - c_real_acc <= cfg_c_real_min, c_imag_acc <= cfg_c_imag_max, x <= 0, y <= 0.
  - Go to ISSUE.
  - frame_start outside IDLE is ignored; cfg_* changes mid-frame have no effect.
- ISSUE:
  - eng_start = 1 for exactly one cycle.
  - eng_c_real/eng_c_imag/eng_max_iter are driven from the accumulators/shadow registers.
  - Go to WAIT.
- WAIT:
  - eng_c_* held stable, because the engine samples c combinationally every iteration.
  - On eng_done, capture eng_iter_count into pix_iter, load pix_x <= x and pix_y <= y, set pix_last = (x==H_RES-1 && y==V_RES-1), assert pix_valid, and go to EMIT.
  - eng_done in any state other than WAIT is ignored.
- EMIT:
  - pix_* held stable while pix_valid && !pix_ready.
  - On accept: pix_valid <= 0.
  - If pix_last, go to FDONE.
  - Else, if x==H_RES-1: x <= 0, y <= y+1, c_real_acc <= shadow min, c_imag_acc <= c_imag_acc - step.
  - Otherwise: x <= x+1, c_real_acc <= c_real_acc + step.
  - Then go to ISSUE.
- FDONE: frame_done = 1 for one cycle, then return to IDLE.
- Accumulator arithmetic is DATA_WIDTH two's-complement wrap, with no saturation. The top row is the maximum imaginary value; y increases downward.
- One engine job is in flight at a time. Minimum per pixel is 3 controller cycles plus engine latency.
- Reset mid-frame aborts immediately to the reset state; no frame_done is produced. The engine shares rst.
- busy = (state != IDLE).

Optional Feature:
- Macro: MANDEL_SCAN_PERF_EN.
- Defined:
  - Adds output perf_frame_cycles[31:0].
  - A cycle counter cleared when a frame is accepted in IDLE increments every non-IDLE cycle.
  - perf_frame_cycles is loaded on the FDONE cycle and holds until the next FDONE. Reset value 0.
  - The counter saturates at 0xFFFFFFFF.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mandelbrot_pkg:
  - DATA_WIDTH/FRAC_WIDTH defaults.
  - Q4.28 constants ONE = 32'h1000_0000 and TWO_NEG = 32'hE000_0000.
  - Controller state enum scan_state_t.
- One natural sub-module: mandelbrot_coord_gen, which holds the x/y counters and the c accumulators and is driven by advance/load strobes.
- Top-level integration instantiates mandelbrot_scan_ctrl and the engine side by side.

Test Plan:
- Configuration for all scenarios: H_RES=4, V_RES=3, behavioural engine model.
- Scenario 1: cfg_c_real_min=32'hE000_0000 (-2.0), cfg_c_imag_max=32'h1000_0000 (1.0), cfg_step=32'h0800_0000 (0.5). Expect:
  - Pixel (0,0) drives c=(E000_0000, 1000_0000).
  - Pixel (3,0) drives c_real=F800_0000.
  - Pixel (0,2) drives c=(E000_0000, 0000_0000).
  - 12 beats total; pix_last only on (3,2).
- Scenario 2: the engine returns count=x+4*y. pix_iter matches for every beat; eng_start pulses exactly 12 times, each one cycle wide; eng_c_* stable from ISSUE through eng_done.
- Scenario 3: hold pix_ready=0 for 5 cycles on beat (1,1). pix_* stay stable; no eng_start is issued until the beat is accepted.
- Scenario 4: frame_start and a cfg_step change mid-frame. Both are ignored; the coordinates still follow the latched step; frame_done pulses once, one cycle after the last beat is accepted.
- Scenario 5: assert rst during WAIT of pixel (2,1). Next cycle all outputs are 0 and busy=0; a new frame_start restarts at (0,0).
- Scenario 6 (MANDEL_SCAN_PERF_EN): engine latency fixed at 10 cycles with pix_ready=1. perf_frame_cycles equals the measured non-IDLE cycle count (12 pixels x 13 cycles + FDONE) at FDONE.
